// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath with one shared ALU and one shared memory port.
// Decodes the IR fields into per-state mux selects, write strobes and the ALU function.
module multicycle_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       RegWrite,
   output logic       illegal_instr,
   output logic       instr_retired
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       rdy;
   logic       pc_update;
   logic       taken;
   logic       retire_nxt;
   logic [1:0] alu_op;

   // With the handshake disabled every memory access completes in its first cycle.
   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

   assign taken = ((funct3 == 3'b000) &&  zero) ||
                  ((funct3 == 3'b001) && !zero);

   assign PCWrite = pc_update || ((state == S_BRANCH) && taken);

   always_comb begin
      state_nxt     = state;
      pc_update     = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      alu_op        = 2'b00;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
      retire_nxt    = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = rdy;
            pc_update = rdy;
            if (rdy) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // Branch/jump target is precomputed here from OldPC + imm.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_R:         state_nxt = S_EXECR;
               OP_I:         state_nxt = S_EXECI;
               OP_BR:        state_nxt = S_BRANCH;
               OP_JAL:       state_nxt = S_JAL;
               default: begin
                  illegal_instr = 1'b1;
                  state_nxt     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            state_nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (rdy) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (rdy) begin
               retire_nxt = 1'b1;
               state_nxt  = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA   = 2'b10;
            alu_op    = 2'b10;
            state_nxt = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            alu_op    = 2'b10;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms the link value.
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            alu_op     = 2'b01;
            retire_nxt = 1'b1;
            state_nxt  = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               // I-type has opcode[5]=0, so IR[30] of an immediate never selects sub.
               3'b000:  ALUControl = (opcode[5] && funct7_5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_FETCH;
         instr_retired <= 1'b0;
      end else begin
         state         <= state_nxt;
         instr_retired <= retire_nxt;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued
// as each cycle's inputs are driven and compared against the outputs on the falling edge.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr, instr_retired;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
      .illegal_instr(illegal_instr), .instr_retired(instr_retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [17:0] vec;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   logic [6:0] cur_op = 7'd0;
   logic [2:0] cur_f3 = 3'd0;
   logic       cur_f7 = 1'b0;
   logic       ret_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, want %b", tag, act, exp);
      end
   endtask

   // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl RegWrite illegal
   function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] alu,
                                      input logic rw, input logic ill);
      logic [1:0] imm;
      case (cur_op)
         OP_SW:   imm = 2'b01;
         OP_BR:   imm = 2'b10;
         OP_JAL:  imm = 2'b11;
         default: imm = 2'b00;
      endcase
      return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
   endfunction

   task automatic cyc(input string tag, input logic rdy, input logic z,
                      input logic [16:0] e, input logic last);
      exp_t x;
      @(posedge clk);
      #1;
      mem_ready = rdy;
      zero      = z;
      opcode    = cur_op;
      funct3    = cur_f3;
      funct7_5  = cur_f7;
      x.tag = tag;
      x.vec = {e, ret_pending};
      sb.push_back(x);
      ret_pending = last;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk(x.tag, {14'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, ALUControl, RegWrite, illegal_instr, instr_retired},
             {14'd0, x.vec});
      end
   end

   task automatic st_fetch(input logic rdy);
      cyc("fetch", rdy, 1'b0, ev(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0), 1'b0);
   endtask
   task automatic st_decode(input logic ill);
      cyc("decode", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, ill), 1'b0);
   endtask
   task automatic st_memadr();
      cyc("memadr", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), 1'b0);
   endtask
   task automatic st_memread(input logic rdy);
      cyc("memread", rdy, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), 1'b0);
   endtask
   task automatic st_memwb();
      cyc("memwb", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0), 1'b1);
   endtask
   task automatic st_memwrite(input logic rdy);
      cyc("memwrite", rdy, 1'b0, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), rdy);
   endtask
   task automatic st_execr(input logic [2:0] alu);
      cyc("execr", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, 0), 1'b0);
   endtask
   task automatic st_execi(input logic [2:0] alu);
      cyc("execi", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, 0), 1'b0);
   endtask
   task automatic st_aluwb();
      cyc("aluwb", 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), 1'b1);
   endtask
   task automatic st_jal();
      cyc("jal", 1'b1, 1'b0, ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0), 1'b0);
   endtask
   task automatic st_branch(input logic z, input logic tk);
      cyc("branch", 1'b1, z, ev(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0), 1'b1);
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      cur_op = op;
      cur_f3 = f3;
      cur_f7 = f7;
   endtask

   // {opcode, funct3, funct7_5, expected ALUControl in EXEC}
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [2:0] alu;
   } alu_case_t;

   alu_case_t alu_tab[7] = '{
      '{OP_R, 3'b000, 1'b0, 3'b000},
      '{OP_R, 3'b000, 1'b1, 3'b001},
      '{OP_R, 3'b010, 1'b0, 3'b101},
      '{OP_R, 3'b110, 1'b0, 3'b011},
      '{OP_R, 3'b111, 1'b0, 3'b010},
      '{OP_I, 3'b000, 1'b1, 3'b000},
      '{OP_I, 3'b010, 1'b0, 3'b101}
   };

   initial begin
      #2;
      chk("rst_irwrite_rdy", {31'd0, IRWrite}, 32'd1);
      chk("rst_pcwrite_rdy", {31'd0, PCWrite}, 32'd1);
      chk("rst_retired", {31'd0, instr_retired}, 32'd0);
      chk("rst_srcb", {30'd0, ALUSrcB}, 32'd2);
      chk("rst_resultsrc", {30'd0, ResultSrc}, 32'd2);
      mem_ready = 1'b0;
      #1;
      chk("rst_irwrite_wait", {31'd0, IRWrite}, 32'd0);
      #9 rst_n = 1'b1;

      foreach (alu_tab[i]) begin
         set_ir(alu_tab[i].op, alu_tab[i].f3, alu_tab[i].f7);
         st_fetch(1'b1);
         st_decode(1'b0);
         if (alu_tab[i].op == OP_R) st_execr(alu_tab[i].alu);
         else                       st_execi(alu_tab[i].alu);
         st_aluwb();
      end

      // lw with two fetch wait cycles and three read wait cycles: 10 cycles total
      set_ir(OP_LW, 3'b010, 1'b0);
      st_fetch(1'b0);
      st_fetch(1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_memadr();
      for (int k = 0; k < 3; k++) st_memread(1'b0);
      st_memread(1'b1);
      st_memwb();

      set_ir(OP_SW, 3'b010, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_memadr();
      st_memwrite(1'b1);

      // beq / bne with both zero values, then an unsupported branch funct3
      for (int k = 0; k < 4; k++) begin
         logic bne;
         logic z;
         bne = k[1];
         z   = k[0];
         set_ir(OP_BR, {2'b00, bne}, 1'b0);
         st_fetch(1'b1);
         st_decode(1'b0);
         st_branch(z, bne ? ~z : z);
      end
      set_ir(OP_BR, 3'b100, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_branch(1'b1, 1'b0);

      set_ir(OP_JAL, 3'b000, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_jal();
      st_aluwb();

      set_ir(7'b0000000, 3'b000, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b1);

      // sw stalled in MEMWRITE, then reset dropped mid-access
      set_ir(OP_SW, 3'b010, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_memadr();
      st_memwrite(1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("rst_mid_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_mid_adrsrc", {31'd0, AdrSrc}, 32'd0);
      chk("rst_mid_srcb", {30'd0, ALUSrcB}, 32'd2);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ret_pending = 1'b0;
      #1;
      chk("rst_mid_retired", {31'd0, instr_retired}, 32'd0);

      set_ir(OP_R, 3'b000, 1'b0);
      st_fetch(1'b1);
      st_decode(1'b0);
      st_execr(3'b000);
      st_aluwb();
      set_ir(OP_LW, 3'b010, 1'b0);
      st_fetch(1'b0);

      @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
